// File: rtl/cmu_pkg.sv
// Shared constants and helpers for the 2-way set-associative cache controller.
package cmu_pkg;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StBack     = 2'd1;
    localparam logic [1:0] StAllocate = 2'd2;

    localparam int unsigned DefAddrW  = 10;
    localparam int unsigned DefIndexW = 3;
    localparam int unsigned DefOffW   = 1;

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned index_w,
                                               input int unsigned off_w);
        return addr_w - index_w - off_w;
    endfunction

    // Word counter keeps at least one bit so single-word lines still have a legal vector.
    function automatic int unsigned calc_cnt_w(input int unsigned off_w);
        return (off_w > 0) ? off_w : 1;
    endfunction

endpackage

// File: rtl/cmu_way.sv
// One way of the cache: valid/dirty/tag per set plus the line data words.
module cmu_way import cmu_pkg::*; #(
    parameter int unsigned INDEX_W = DefIndexW,
    parameter int unsigned OFF_W   = DefOffW,
    parameter int unsigned TAG_W   = 6
) (
    input  logic                     clka,
    input  logic                     rst,
    input  logic [INDEX_W+OFF_W-1:0] word_i,
    input  logic [TAG_W-1:0]         cmp_tag_i,
    output logic                     hit_o,
    output logic                     valid_o,
    output logic                     dirty_o,
    output logic [TAG_W-1:0]         tag_o,
    output logic [31:0]              data_o,
    input  logic                     wr_en_i,
    input  logic [31:0]              wr_data_i,
    input  logic                     fill_en_i,
    input  logic [31:0]              fill_data_i,
    input  logic                     fill_done_i,
    input  logic [TAG_W-1:0]         fill_tag_i
);
    localparam int unsigned LoW   = INDEX_W + OFF_W;
    localparam int unsigned Sets  = 2 ** INDEX_W;
    localparam int unsigned Words = 2 ** LoW;

    logic [Sets-1:0]    valid_q;
    logic [Sets-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_q  [Sets];
    logic [31:0]        data_q [Words];
    logic [INDEX_W-1:0] idx;

    assign idx     = word_i[LoW-1:OFF_W];
    assign valid_o = valid_q[idx];
    assign dirty_o = dirty_q[idx];
    assign tag_o   = tag_q[idx];
    assign data_o  = data_q[word_i];
    assign hit_o   = valid_q[idx] && (tag_q[idx] == cmp_tag_i);

    always_ff @(posedge clka) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done_i) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits guard them.
    always_ff @(posedge clka) begin
        if (fill_done_i) begin
            tag_q[idx] <= fill_tag_i;
        end
        if (wr_en_i) begin
            data_q[word_i] <= wr_data_i;
        end else if (fill_en_i) begin
            data_q[word_i] <= fill_data_i;
        end
    end

endmodule

// File: rtl/assoc_cmu.sv
// 2-way set-associative write-back cache controller: FSM, LRU bits and victim selection.
module assoc_cmu import cmu_pkg::*; #(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned INDEX_W = DefIndexW,
    parameter int unsigned OFF_W   = DefOffW
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              cs,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [31:0]       dina,
    output logic [31:0]       douta,
    output logic              ack,
    output logic              mem_cs,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [31:0]       mem_dina,
    input  logic [31:0]       mem_douta,
    input  logic              mem_ack
);
    localparam int unsigned TAG_W = calc_tag_w(ADDR_W, INDEX_W, OFF_W);
    localparam int unsigned LO_W  = INDEX_W + OFF_W;
    localparam int unsigned CNT_W = calc_cnt_w(OFF_W);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'((2 ** OFF_W) - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAG_W-1:0]    r_tag_q, r_tag_d;
    logic [INDEX_W-1:0]  r_idx_q, r_idx_d;
    logic                r_way_q, r_way_d;
    logic [2**INDEX_W-1:0] lru_q, lru_d;

    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_idx;
    logic [LO_W-1:0]    cpu_lo, lat_lo, way_lo;

    logic [1:0]       hit, way_valid, way_dirty, wr_en, fill_en, fill_done;
    logic [TAG_W-1:0] way_tag  [2];
    logic [31:0]      way_data [2];
    logic             victim;

    assign cpu_tag = addra[ADDR_W-1:LO_W];
    assign cpu_idx = addra[LO_W-1:OFF_W];
    assign cpu_lo  = addra[LO_W-1:0];
    // Transfers address the latched set, never the live CPU address.
    assign lat_lo  = (LO_W'(r_idx_q) << OFF_W) | LO_W'(cnt_q);
    assign way_lo  = (state_q == StIdle) ? cpu_lo : lat_lo;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cmu_way #(
            .INDEX_W (INDEX_W),
            .OFF_W   (OFF_W),
            .TAG_W   (TAG_W)
        ) u_way (
            .clka        (clka),
            .rst         (rst),
            .word_i      (way_lo),
            .cmp_tag_i   (cpu_tag),
            .hit_o       (hit[w]),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .data_o      (way_data[w]),
            .wr_en_i     (wr_en[w] && !rst),
            .wr_data_i   (dina),
            .fill_en_i   (fill_en[w] && !rst),
            .fill_data_i (mem_douta),
            .fill_done_i (fill_done[w] && !rst),
            .fill_tag_i  (r_tag_q)
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_tag_d   = r_tag_q;
        r_idx_d   = r_idx_q;
        r_way_d   = r_way_q;
        lru_d     = lru_q;
        victim    = 1'b0;
        ack       = 1'b0;
        douta     = '0;
        mem_cs    = 1'b0;
        mem_wea   = 1'b0;
        mem_addra = '0;
        mem_dina  = '0;
        wr_en     = '0;
        fill_en   = '0;
        fill_done = '0;
        case (state_q)
            StIdle: begin
                if (cs) begin
                    if (|hit) begin
                        ack = 1'b1;
                        if (wea) begin
                            wr_en = hit;
                        end else begin
                            douta = hit[1] ? way_data[1] : way_data[0];
                        end
                        lru_d[cpu_idx] = ~hit[1];
                    end else begin
                        victim  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[cpu_idx]);
                        r_tag_d = cpu_tag;
                        r_idx_d = cpu_idx;
                        r_way_d = victim;
                        cnt_d   = '0;
                        state_d = (way_valid[victim] && way_dirty[victim]) ? StBack : StAllocate;
                    end
                end
            end
            StBack: begin
                mem_cs    = !mem_ack;
                mem_wea   = 1'b1;
                mem_addra = {way_tag[r_way_q], lat_lo};
                mem_dina  = way_data[r_way_q];
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StAllocate;
                    end
                end
            end
            StAllocate: begin
                mem_cs    = !mem_ack;
                mem_addra = {r_tag_q, lat_lo};
                if (mem_ack) begin
                    fill_en[r_way_q] = 1'b1;
                    cnt_d            = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        cnt_d              = '0;
                        fill_done[r_way_q] = 1'b1;
                        lru_d[r_idx_q]     = ~r_way_q;
                        state_d            = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_tag_q <= '0;
            r_idx_q <= '0;
            r_way_q <= 1'b0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_tag_q <= r_tag_d;
            r_idx_q <= r_idx_d;
            r_way_q <= r_way_d;
            lru_q   <= lru_d;
        end
    end

endmodule
